// File: rtl/hub75_bcm_driver.sv
// HUB75 panel scan driver: binary-coded modulation over COLOR_BITS planes, double-buffered
// frame store read from an external synchronous RAM, swap taken only at frame boundaries.
module hub75_bcm_driver #(
    parameter int unsigned COLS       = 32,
    parameter int unsigned SCAN       = 8,
    parameter int unsigned COLOR_BITS = 4,
    parameter int unsigned BASE_TIME  = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  enable,
    output logic [$clog2(SCAN)+$clog2(COLS):0]    rd_addr,
    input  logic [6*COLOR_BITS-1:0]               rd_data,
    output logic [5:0]                            rgb,
    output logic                                  sclk,
    output logic                                  lat,
    output logic                                  oe,
    output logic [$clog2(SCAN)-1:0]               abc,
    input  logic                                  swap_req,
    output logic                                  swap_ack,
    output logic                                  frame_done,
    output logic                                  buf_sel
);

    localparam int unsigned RW = $clog2(SCAN);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned SW = $clog2(2 * COLS + 1);
    localparam int unsigned PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int unsigned DW = $clog2(BASE_TIME << (COLOR_BITS - 1)) + 1;
    localparam int unsigned AW = 1 + RW + CW;

    typedef enum logic [1:0] {StIdle, StShift, StLatch, StDisplay} state_e;

    state_e          st_q, st_d;
    logic [SW-1:0]   step_q, step_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   plane_q, plane_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [DW-1:0]   dlen;
    logic            buf_d;
    logic            frame_end;

    logic [AW-1:0]   rd_addr_d;
    logic [5:0]      rgb_d;
    logic            sclk_d, lat_d, oe_d;
    logic [RW-1:0]   abc_d;

    // Index of the final DISPLAY cycle for the current plane.
    always_comb dlen = (DW'(BASE_TIME) << plane_q) - DW'(1);

    always_comb begin
        st_d      = st_q;
        step_d    = step_q;
        row_d     = row_q;
        plane_d   = plane_q;
        dcnt_d    = dcnt_q;
        buf_d     = buf_sel;
        frame_end = 1'b0;
        case (st_q)
            StIdle: begin
                if (enable) begin
                    st_d    = StShift;
                    step_d  = '0;
                    row_d   = '0;
                    plane_d = '0;
                end
            end
            StShift: begin
                if (step_q == SW'(2 * COLS)) begin
                    st_d = StLatch;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            StLatch: begin
                st_d   = StDisplay;
                dcnt_d = '0;
            end
            StDisplay: begin
                if (dcnt_q == dlen) begin
                    step_d = '0;
                    if (plane_q != PW'(COLOR_BITS - 1)) begin
                        plane_d = plane_q + PW'(1);
                        st_d    = StShift;
                    end else if (row_q != RW'(SCAN - 1)) begin
                        plane_d = '0;
                        row_d   = row_q + RW'(1);
                        st_d    = StShift;
                    end else begin
                        frame_end = 1'b1;
                        plane_d   = '0;
                        row_d     = '0;
                        if (swap_req) buf_d = ~buf_sel;
                        st_d = enable ? StShift : StIdle;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: st_d = StIdle;
        endcase
    end

    // Panel pins are decoded from the current state and registered, so they trail the
    // internal sequence by one cycle; rd_addr is decoded from the next state so RAM data
    // is ready on the odd SHIFT steps.
    always_comb begin
        rgb_d     = rgb;
        abc_d     = abc;
        rd_addr_d = rd_addr;
        sclk_d    = (st_q == StShift) && !step_q[0] && (step_q != '0);
        lat_d     = (st_q == StLatch);
        oe_d      = (st_q != StDisplay);
        if (st_q == StShift && step_q[0]) begin
            for (int i = 0; i < 6; i++) begin
                rgb_d[i] = rd_data[i * COLOR_BITS + int'(plane_q)];
            end
        end
        if (st_q == StLatch) abc_d = row_q;
        if (st_d == StShift && !step_d[0] && step_d != SW'(2 * COLS)) begin
            rd_addr_d = {buf_d, row_d, CW'(step_d >> 1)};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= StIdle;
            step_q     <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            dcnt_q     <= '0;
            buf_sel    <= 1'b0;
            rd_addr    <= '0;
            rgb        <= '0;
            sclk       <= 1'b0;
            lat        <= 1'b0;
            oe         <= 1'b1;
            abc        <= '0;
            swap_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            st_q       <= st_d;
            step_q     <= step_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            dcnt_q     <= dcnt_d;
            buf_sel    <= buf_d;
            rd_addr    <= rd_addr_d;
            rgb        <= rgb_d;
            sclk       <= sclk_d;
            lat        <= lat_d;
            oe         <= oe_d;
            abc        <= abc_d;
            swap_ack   <= frame_end && swap_req;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver at COLS=4, SCAN=2, COLOR_BITS=2, BASE_TIME=2.
module tb_hub75_bcm_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        swap_req = 1'b0;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;
    logic [5:0]  rgb;
    logic        sclk, lat, oe;
    logic [0:0]  abc;
    logic        swap_ack, frame_done, buf_sel;

    logic [11:0] mem [16];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_on = 1'b0;
    int          n_rise_total = 0;
    int          n_oe_low_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    hub75_bcm_driver #(
        .COLS(4), .SCAN(2), .COLOR_BITS(2), .BASE_TIME(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rgb        (rgb),
        .sclk       (sclk),
        .lat        (lat),
        .oe         (oe),
        .abc        (abc),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_done (frame_done),
        .buf_sel    (buf_sel)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected rgb on the k-th sclk rise of a frame (4 rises per shift, shifts ordered
    // row0/p0, row0/p1, row1/p0, row1/p1).
    function automatic logic [5:0] exp_rgb(input int k);
        case (k)
            10:      return 6'b000001;
            14:      return 6'b100000;
            11, 15:  return 6'b111111;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic wait_fd(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1'b1;
        end
        check_eq(tag, 32'(got), 32'd1);
    endtask

    // Continuous negedge monitor for panel timing and data.
    initial begin
        int   cyc = 0, k_rise = 0, shift_rise = 0, oe_low = 0, oe_high = 0;
        int   exp_len = 2, last_fd = 0;
        bit   fd_valid = 1'b0;
        logic prev_sclk = 1'b0, prev_lat = 1'b0, prev_oe = 1'b1;
        logic [0:0] prev_abc = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_on) begin
                if (sclk && !prev_sclk) begin
                    check_eq($sformatf("rgb_rise%0d", k_rise), 32'(rgb), 32'(exp_rgb(k_rise)));
                    k_rise++;
                    shift_rise++;
                    n_rise_total++;
                end
                if (lat) begin
                    check_eq("lat_width", 32'(prev_lat), 32'd0);
                    check_eq("rises_per_shift", 32'(shift_rise), 32'd4);
                    check_eq("oe_at_lat", 32'(oe), 32'd1);
                    shift_rise = 0;
                end
                if (abc != prev_abc) check_eq("abc_change_blanked", 32'({oe, lat}), 32'd3);
                if (!oe) begin
                    oe_low++;
                    n_oe_low_total++;
                    oe_high = 0;
                end else begin
                    if (!prev_oe) begin
                        check_eq("oe_low_len", 32'(oe_low), 32'(exp_len));
                        exp_len = (exp_len == 2) ? 4 : 2;
                    end
                    oe_low = 0;
                    oe_high++;
                    if (oe_high > 12) fd_valid = 1'b0;
                end
                if (frame_done) begin
                    if (fd_valid) check_eq("frame_period", 32'(cyc - last_fd), 32'd52);
                    last_fd  = cyc;
                    fd_valid = 1'b1;
                    k_rise   = 0;
                end
            end
            prev_sclk = sclk;
            prev_lat  = lat;
            prev_oe   = oe;
            prev_abc  = abc;
        end
    end

    initial begin
        int  bad;
        int  r0, lo0;
        bit  found;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[4'b0110] = 12'b10_00_00_00_00_01;
        mem[4'b1110] = 12'b10_00_00_00_00_01;
        mem[4'b0111] = 12'hfff;
        mem[4'b1111] = 12'hfff;

        repeat (3) @(negedge clk);
        check_eq("rst_oe", 32'(oe), 32'd1);
        check_eq("rst_rgb", 32'(rgb), 32'd0);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_lat", 32'(lat), 32'd0);
        check_eq("rst_abc", 32'(abc), 32'd0);
        check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
        check_eq("rst_buf_sel", 32'(buf_sel), 32'd0);
        check_eq("rst_swap_ack", 32'(swap_ack), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);

        reset_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (!oe || sclk) bad++;
        end
        check_eq("idle_quiet", 32'(bad), 32'd0);

        mon_on = 1'b1;
        enable = 1'b1;
        wait_fd("fd_first");
        wait_fd("fd_second");
        wait_fd("fd_third");
        check_eq("no_swap_ack", 32'(swap_ack), 32'd0);
        check_eq("buf_sel_0", 32'(buf_sel), 32'd0);

        // Short swap pulse mid-frame must be ignored.
        repeat (10) @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        wait_fd("fd_after_pulse");
        check_eq("pulse_swap_ack", 32'(swap_ack), 32'd0);
        check_eq("pulse_buf_sel", 32'(buf_sel), 32'd0);

        // Held request: one swap per frame.
        swap_req = 1'b1;
        wait_fd("fd_swap1");
        check_eq("swap1_ack", 32'(swap_ack), 32'd1);
        check_eq("swap1_buf_sel", 32'(buf_sel), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("swap1_rd_addr_msb", 32'(rd_addr[3]), 32'd1);
        wait_fd("fd_swap2");
        check_eq("swap2_ack", 32'(swap_ack), 32'd1);
        check_eq("swap2_buf_sel", 32'(buf_sel), 32'd0);
        swap_req = 1'b0;
        wait_fd("fd_noswap");
        check_eq("noswap_ack", 32'(swap_ack), 32'd0);
        check_eq("noswap_buf_sel", 32'(buf_sel), 32'd0);

        // Enable drop during row 0: frame completes, then idle.
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_fd("fd_enable_drop");
        repeat (3) @(negedge clk);
        r0  = n_rise_total;
        lo0 = n_oe_low_total;
        repeat (60) @(negedge clk);
        check_eq("idle_no_sclk", 32'(n_rise_total), 32'(r0));
        check_eq("idle_no_oe_low", 32'(n_oe_low_total), 32'(lo0));
        check_eq("idle_oe", 32'(oe), 32'd1);

        // Move to buffer 1, then reset asynchronously during row 1 display.
        swap_req = 1'b1;
        enable   = 1'b1;
        wait_fd("fd_swap_pre_reset");
        swap_req = 1'b0;
        check_eq("pre_reset_buf_sel", 32'(buf_sel), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (abc == 1'b1 && !oe) found = 1'b1;
        end
        check_eq("found_row1_display", 32'(found), 32'd1);
        mon_on = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_oe", 32'(oe), 32'd1);
        check_eq("async_rgb", 32'(rgb), 32'd0);
        check_eq("async_lat", 32'(lat), 32'd0);
        check_eq("async_abc", 32'(abc), 32'd0);
        check_eq("async_buf_sel", 32'(buf_sel), 32'd0);
        check_eq("async_rd_addr", 32'(rd_addr), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!oe || sclk) bad++;
        end
        check_eq("post_reset_idle", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
Parametrised HUB75 LED-panel scan driver. Generalises the single-colour, fixed 32x16 panel driver to arbitrary column count and scan depth, multi-bit colour per channel via binary-coded modulation (BCM), and a double-buffered frame store with a swap handshake. Reads pixels from an external synchronous frame-buffer RAM and drives the panel's rgb, sclk, lat, oe and row-address pins.

Parameters:
COLS, 32, panel columns shifted per row; power of 2, at least 2.
SCAN, 8, row pairs (scan lines); panel has 2*SCAN rows; power of 2, at least 2.
COLOR_BITS, 4, bits per colour channel, which is also the number of BCM planes.
BASE_TIME, 8, DISPLAY cycles for plane 0; plane b displays BASE_TIME<<b cycles.

Ports:
clk  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
enable  in  1  start and continue frame scanning
rd_addr  out  1+log2(SCAN)+log2(COLS)  {buf_sel, row, col} address to frame RAM
rd_data  in  6*COLOR_BITS  {R1,G1,B1,R2,G2,B2}, each COLOR_BITS wide, R1 at MSBs; valid 1 cycle after rd_addr
rgb  out  6  {R1,G1,B1,R2,G2,B2} panel data bits
sclk  out  1  panel shift clock
lat  out  1  panel latch strobe, active high
oe  out  1  panel blank, high = LEDs off
abc  out  log2(SCAN)  panel row address
swap_req  in  1  request display-buffer swap at the next frame boundary
swap_ack  out  1  1-cycle pulse when the swap takes effect
frame_done  out  1  1-cycle pulse at the end of each frame
buf_sel  out  1  buffer currently displayed

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0): rgb=0, sclk=0, lat=0, oe=1, abc=0, rd_addr=0, buf_sel=0, swap_ack=0, frame_done=0. FSM goes to IDLE; row, plane and column counters clear. Reset asserted mid-operation forces these values immediately.
- FSM states: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: oe=1. If enable=1, go to SHIFT with row=0, plane=0.
- SHIFT lasts 2*COLS+1 cycles, indexed s=0..2*COLS. oe=1 throughout.
  - s=0: issue rd_addr for col 0.
  - s=2c+1: rgb is set to bit[plane] of each channel field of rd_data for col c; sclk=0; issue rd_addr for col c+1 (no issue when c=COLS-1).
  - s=2c+2: sclk=1 with rgb held.
  - Column 0 is shifted first.
- LATCH: 1 cycle. lat=1, sclk=0, oe=1. abc updates to the current row in this cycle.
- DISPLAY: oe=0 for exactly BASE_TIME<<plane cycles. Then:
  - if plane<COLOR_BITS-1: plane+1, go to SHIFT;
  - else if row<SCAN-1: plane=0, row+1, go to SHIFT;
  - else the frame ends.
- Frame end:
  - frame_done pulses 1 cycle.
  - If swap_req=1 in the last DISPLAY cycle, buf_sel toggles and swap_ack pulses in the same cycle as frame_done.
  - Next state is SHIFT (row 0) if enable=1, else IDLE.
- enable=0 mid-frame: the current frame completes and the FSM then goes to IDLE. No partial frames.
- Frame length in cycles: SCAN*sum over b of (2*COLS+2+(BASE_TIME<<b)).
- Counters wrap cleanly. Row and address widths are exact log2, with no overflow into buf_sel.
- swap_req held high across several frames produces one swap per frame.

Test Plan:
- Reset: reset_n=0 mid-DISPLAY -> oe=1, rgb=0, lat=0, abc=0, buf_sel=0 without waiting for a clock edge. After release with enable=0, the FSM stays IDLE and oe stays 1.
- Timing (COLS=4, SCAN=2, COLOR_BITS=2, BASE_TIME=2, enable=1):
  - 4 sclk rising edges per SHIFT;
  - lat high 1 cycle after each SHIFT;
  - oe low for 2 cycles (plane 0), then 4 cycles (plane 1);
  - frame_done every 52 cycles.
- Data mapping: RAM col 2 of row 1 = R1=2'b10, B2=2'b01, all other fields 0 -> on the 3rd sclk rise of row 1: plane 0 gives rgb=6'b000001, plane 1 gives rgb=6'b100000.
- Row address: abc changes only in LATCH cycles while oe=1. abc is never seen changing while oe=0.
- Swap: swap_req=1 for one cycle mid-frame, then low -> no swap. swap_req held high -> buf_sel toggles and swap_ack=1 coincident with frame_done; the next frame's rd_addr MSB=1.
- Enable drop: enable=0 during row 0 -> the frame completes, frame_done pulses, the FSM enters IDLE, and no further sclk edges occur.
